// File: rtl/pps_pkg.sv
// Shared definitions for the multi-channel PPS capture: record layout, header bits, frame sizing.
package pps_pkg;

    localparam int unsigned CH_W      = 4;
    localparam int unsigned HDR_FIRST = 7;
    localparam int unsigned HDR_SAT   = 6;

    // Record = {ch[3:0], FIRST, SAT, count[cnt_w-1:0]}
    function automatic int unsigned rec_w(input int unsigned cnt_w);
        return CH_W + 2 + cnt_w;
    endfunction

    function automatic int unsigned nbytes(input int unsigned cnt_w);
        return (cnt_w + 7) / 8;
    endfunction

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

endpackage

// File: rtl/pps_chan_frontend.sv
// One pulse channel: synchroniser, stability filter, edge detect, period counter, holding register.
module pps_chan_frontend
    import pps_pkg::*;
#(
    parameter int unsigned CH    = 0,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned FILT  = 3,
    localparam int unsigned REC_W = CH_W + 2 + CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pps,
    input  logic             edge_sel,
    input  logic             grant,
    output logic             hold_valid,
    output logic [REC_W-1:0] hold_rec,
    output logic             drop_flag
);

    localparam int unsigned RW = $clog2(FILT + 1);
    localparam logic [RW-1:0] FILT_R = RW'(FILT);

    logic             sync1, sync2, sync_prev;
    logic [RW-1:0]    run_q, run_now;
    logic             level, level_d, seen;
    logic [CNT_W-1:0] cnt, period;
    logic             cnt_max, edge_det;

    // run_now counts consecutive identical synchronised samples, including the current one
    always_comb begin
        run_now = run_q;
        if (sync2 != sync_prev)
            run_now = RW'(1);
        else if (run_q != FILT_R)
            run_now = run_q + 1'b1;
    end

    always_comb begin
        cnt_max  = &cnt;
        period   = cnt_max ? cnt : cnt + 1'b1;
        edge_det = edge_sel ? (level & ~level_d) : (~level & level_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            run_q      <= FILT_R;
            level      <= 1'b0;
            level_d    <= 1'b0;
            seen       <= 1'b0;
            cnt        <= '0;
            hold_valid <= 1'b0;
            hold_rec   <= '0;
            drop_flag  <= 1'b0;
        end else begin
            sync1     <= pps;
            sync2     <= sync1;
            sync_prev <= sync2;
            run_q     <= run_now;
            if (run_now == FILT_R)
                level <= sync2;
            level_d <= level;

            if (edge_det) begin
                cnt  <= '0;
                seen <= 1'b1;
            end else if (!cnt_max) begin
                cnt <= cnt + 1'b1;
            end

            // A slot freed by this cycle's grant can take the new record at once
            if (edge_det && (!hold_valid || grant)) begin
                hold_valid <= 1'b1;
                hold_rec   <= {CH_W'(CH), ~seen, cnt_max, period};
            end else if (grant) begin
                hold_valid <= 1'b0;
            end

            if (edge_det && hold_valid && !grant)
                drop_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/pps_capture_multi.sv
// Multi-channel PPS period capture: per-channel frontends, fixed-priority arbiter, record FIFO, byte serializer.
module pps_capture_multi
    import pps_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FILT       = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] pps,
    input  logic [NCH-1:0] edge_sel,
    output logic [7:0]     out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic [NCH-1:0] drop_flag
);

    localparam int unsigned REC_W  = rec_w(CNT_W);
    localparam int unsigned NBYTES = nbytes(CNT_W);
    localparam int unsigned PAD_W  = NBYTES * 8;
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned IW     = $clog2(NBYTES + 1);

    logic [NCH-1:0]   hold_valid, grant;
    logic [REC_W-1:0] hold_rec [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pps_chan_frontend #(
            .CH    (g),
            .CNT_W (CNT_W),
            .FILT  (FILT)
        ) u_fe (
            .clk        (clk),
            .reset      (reset),
            .pps        (pps[g]),
            .edge_sel   (edge_sel[g]),
            .grant      (grant[g]),
            .hold_valid (hold_valid[g]),
            .hold_rec   (hold_rec[g]),
            .drop_flag  (drop_flag[g])
        );
    end

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]    count;
    logic             fifo_full, push, pop;
    logic [REC_W-1:0] push_rec;
    ser_state_t       state;
    logic [IW-1:0]    idx;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec, input logic [IW-1:0] i);
        logic [PAD_W-1:0] padded;
        logic [7:0]       b;
        padded = PAD_W'(rec[CNT_W-1:0]);
        if (i == '0) begin
            b            = '0;
            b[HDR_FIRST] = rec[CNT_W+1];
            b[HDR_SAT]   = rec[CNT_W];
            b[3:0]       = rec[REC_W-1 -: CH_W];
        end else begin
            b = 8'(padded >> ((NBYTES - 32'(i)) * 8));
        end
        return b;
    endfunction

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign rd_next   = ptr_inc(rd_ptr);
    // The frame being sent stays at the FIFO head until its last byte is accepted
    assign pop       = (state == SER_SEND) && out_ready && out_last;

    always_comb begin
        grant    = '0;
        push     = 1'b0;
        push_rec = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!push && hold_valid[i] && !fifo_full) begin
                grant[i] = 1'b1;
                push     = 1'b1;
                push_rec = hold_rec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[AW'(i)] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= rd_next;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SER_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (count != '0) begin
                        state     <= SER_SEND;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_data  <= frame_byte(mem[rd_ptr], '0);
                        idx       <= '0;
                    end
                end
                SER_SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            if (count > CW'(1)) begin
                                out_data <= frame_byte(mem[rd_next], '0);
                                out_last <= 1'b0;
                                idx      <= '0;
                            end else begin
                                state     <= SER_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            idx      <= idx + 1'b1;
                            out_data <= frame_byte(mem[rd_ptr], idx + 1'b1);
                            out_last <= ((idx + 1'b1) == IW'(NBYTES));
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pps_capture_multi.sv
// Self-checking bench for pps_capture_multi: directed scenarios plus randomized pulses against a period model.
module tb_pps_capture_multi;

    localparam int FILT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] pps = '0, esel = 2'b11, drop;
    logic [7:0] od;
    logic       ov, ol, ordy = 1'b1;
    logic [1:0] pps8 = '0, esel8 = 2'b11, drop8;
    logic [7:0] od8;
    logic       ov8, ol8, ordy8 = 1'b1;

    int chk = 0;
    int pass = 0;

    always #5 clk = ~clk;

    pps_capture_multi #(.NCH(2), .CNT_W(32), .FILT(FILT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pps(pps), .edge_sel(esel), .out_data(od),
        .out_valid(ov), .out_ready(ordy), .out_last(ol), .drop_flag(drop));

    pps_capture_multi #(.NCH(2), .CNT_W(8), .FILT(FILT), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .pps(pps8), .edge_sel(esel8), .out_data(od8),
        .out_valid(ov8), .out_ready(ordy8), .out_last(ol8), .drop_flag(drop8));

    typedef struct { logic [39:0] data; int len; } frame_t;
    typedef struct { int ch; logic first; logic sat; logic [31:0] cnt; } rec_t;

    frame_t frames[$], frames8[$];
    rec_t   expq[$];

    // Frame collectors: a byte transfers at the next rising edge when valid && ready
    logic [39:0] acc = '0, acc8 = '0;
    int nb = 0, nb8 = 0;
    always @(negedge clk) begin
        if (reset) begin
            acc = '0; nb = 0; acc8 = '0; nb8 = 0;
        end else begin
            if (ov && ordy) begin
                acc = {acc[31:0], od}; nb++;
                if (ol) begin frames.push_back('{acc, nb}); acc = '0; nb = 0; end
            end
            if (ov8 && ordy8) begin
                acc8 = {acc8[31:0], od8}; nb8++;
                if (ol8) begin frames8.push_back('{acc8, nb8}); acc8 = '0; nb8 = 0; end
            end
        end
    end

    // Period model: a level is accepted after FILT equal samples; a selected edge yields the cycle gap
    longint mcyc = 0;
    longint m_last[2];
    int     m_run[2];
    logic   m_level[2], m_prev[2], m_seen[2];
    always @(posedge clk) begin
        mcyc++;
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_level[c] = 1'b0; m_prev[c] = 1'b0; m_run[c] = FILT; m_seen[c] = 1'b0;
            end else begin
                if (pps[c] == m_prev[c]) m_run[c]++; else m_run[c] = 1;
                m_prev[c] = pps[c];
                if (m_run[c] >= FILT && pps[c] != m_level[c]) begin
                    m_level[c] = pps[c];
                    if (pps[c] == esel[c]) begin
                        longint p;
                        rec_t r;
                        p = mcyc - m_last[c];
                        r.ch = c; r.first = ~m_seen[c];
                        r.sat = (p > 64'hFFFF_FFFF);
                        r.cnt = r.sat ? 32'hFFFF_FFFF : p[31:0];
                        expq.push_back(r);
                        m_last[c] = mcyc; m_seen[c] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1; tick(2);
        chk++; if (ov !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", ov); else pass++;
        chk++; if (ol !== 1'b0) $display("FAIL reset_last: got %0h expected 0", ol); else pass++;
        chk++; if (od !== 8'h00) $display("FAIL reset_data: got %0h expected 0", od); else pass++;
        chk++; if (drop !== 2'b00) $display("FAIL reset_drop: got %0h expected 0", drop); else pass++;
        chk++; if (ov8 !== 1'b0) $display("FAIL reset_valid8: got %0h expected 0", ov8); else pass++;
        chk++; if (drop8 !== 2'b00) $display("FAIL reset_drop8: got %0h expected 0", drop8); else pass++;
        reset = 1'b0; tick(1);
    endtask

    task automatic test_latency;
        frames.delete();
        tick(96);
        pps[0] = 1'b1;
        repeat (FILT + 4) @(posedge clk);
        #1;
        chk++; if (ov !== 1'b0) $display("FAIL lat_early: got valid %0h expected 0", ov); else pass++;
        @(posedge clk); #1;
        chk++; if (ov !== 1'b1) $display("FAIL lat_valid: got valid %0h expected 1", ov); else pass++;
        chk++; if (od !== 8'h80) $display("FAIL lat_header: got %0h expected 80", od); else pass++;
        tick(20);
        pps[0] = 1'b0;
        tick(20);
        chk++; if (frames.size() != 1) $display("FAIL lat_frames: got %0d expected 1", frames.size()); else pass++;
        if (frames.size() >= 1) begin
            chk++; if (frames[0].len != 5) $display("FAIL lat_len: got %0d expected 5", frames[0].len); else pass++;
            chk++; if (frames[0].data[39:32] !== 8'h80) $display("FAIL lat_frame_hdr: got %0h expected 80", frames[0].data[39:32]); else pass++;
        end
    endtask

    task automatic test_period;
        frames.delete();
        pps[0] = 1'b1; tick(100);
        pps[0] = 1'b0; tick(900);
        pps[0] = 1'b1; tick(100);
        pps[0] = 1'b0;
        for (int i = 0; i < 200 && frames.size() < 2; i++) tick(1);
        chk++; if (frames.size() != 2) $display("FAIL per_frames: got %0d expected 2", frames.size()); else pass++;
        if (frames.size() >= 2) begin
            chk++; if (frames[1].data !== 40'h00_0000_03E8) $display("FAIL per_bytes: got %010h expected 00000003e8", frames[1].data); else pass++;
            chk++; if (frames[1].len != 5) $display("FAIL per_len: got %0d expected 5", frames[1].len); else pass++;
        end
    endtask

    task automatic test_glitch;
        frames.delete();
        pps[1] = 1'b1; tick(1);
        pps[1] = 1'b0; tick(30);
        pps[1] = 1'b1; tick(FILT - 1);
        pps[1] = 1'b0; tick(40);
        chk++; if (frames.size() != 0) $display("FAIL glitch_none: got %0d frames expected 0", frames.size()); else pass++;
        pps[1] = 1'b1; tick(FILT);
        pps[1] = 1'b0; tick(40);
        chk++; if (frames.size() != 1) $display("FAIL glitch_one: got %0d frames expected 1", frames.size()); else pass++;
        if (frames.size() >= 1) begin
            chk++; if (frames[0].data[39:32] !== 8'h81) $display("FAIL glitch_hdr: got %0h expected 81", frames[0].data[39:32]); else pass++;
        end
    endtask

    task automatic test_simultaneous;
        frames.delete();
        pps = 2'b11; tick(20);
        pps = 2'b00; tick(480);
        pps = 2'b11; tick(20);
        pps = 2'b00;
        for (int i = 0; i < 100 && frames.size() < 4; i++) tick(1);
        chk++; if (frames.size() != 4) $display("FAIL sim_frames: got %0d expected 4", frames.size()); else pass++;
        if (frames.size() >= 4) begin
            chk++; if (frames[0].data[35:32] !== 4'd0) $display("FAIL sim_order0: got ch %0d expected 0", frames[0].data[35:32]); else pass++;
            chk++; if (frames[2].data !== 40'h00_0000_01F4) $display("FAIL sim_ch0: got %010h expected 00000001f4", frames[2].data); else pass++;
            chk++; if (frames[3].data !== 40'h01_0000_01F4) $display("FAIL sim_ch1: got %010h expected 01000001f4", frames[3].data); else pass++;
        end
        chk++; if (drop !== 2'b00) $display("FAIL sim_drop: got %0h expected 0", drop); else pass++;
    endtask

    task automatic test_backpressure;
        frames.delete();
        ordy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pps[0] = 1'b1; tick(5);
            pps[0] = 1'b0; tick(5);
            if (i == 10 || i == 19) begin
                chk++; if (ov !== 1'b1 || ol !== 1'b0) $display("FAIL bp_hold: got valid %0h last %0h expected 1 0", ov, ol); else pass++;
                chk++; if (od !== 8'h00) $display("FAIL bp_data: got %0h expected 00", od); else pass++;
            end
        end
        chk++; if (drop !== 2'b01) $display("FAIL bp_drop: got %0h expected 1", drop); else pass++;
        ordy = 1'b1;
        for (int i = 0; i < 200 && frames.size() < 5; i++) tick(1);
        tick(50);
        chk++; if (frames.size() != 5) $display("FAIL bp_kept: got %0d expected 5", frames.size()); else pass++;
        for (int i = 1; i < 5 && i < frames.size(); i++) begin
            chk++; if (frames[i].data !== 40'h00_0000_000A) $display("FAIL bp_rec%0d: got %010h expected 000000000a", i, frames[i].data); else pass++;
        end
    endtask

    task automatic test_random;
        int tmr[2];
        int n_exp;
        reset = 1'b1; pps = '0; tick(2);
        reset = 1'b0; tick(1);
        frames.delete(); expq.delete();
        esel = 2'($urandom_range(0, 3));
        tmr[0] = $urandom_range(10, 40); tmr[1] = $urandom_range(10, 40);
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (tmr[c] == 0) begin
                    pps[c] = ~pps[c];
                    tmr[c] = ($urandom_range(0, 6) == 0) ? $urandom_range(1, FILT - 1) : $urandom_range(25, 70);
                end else begin
                    tmr[c]--;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        pps = '0; ordy = 1'b1; tick(20);
        n_exp = expq.size();
        for (int i = 0; i < 400 && frames.size() < n_exp; i++) tick(1);
        tick(20);
        chk++; if (frames.size() != n_exp) $display("FAIL rand_count: got %0d frames expected %0d", frames.size(), n_exp); else pass++;
        chk++; if (drop !== 2'b00) $display("FAIL rand_drop: got %0h expected 0", drop); else pass++;
        for (int f = 0; f < frames.size(); f++) begin
            int k;
            logic [7:0] eh;
            k = -1;
            for (int e = 0; e < expq.size(); e++)
                if (k < 0 && expq[e].ch == int'(frames[f].data[35:32])) k = e;
            chk++;
            if (k < 0) begin
                $display("FAIL rand_match: frame %0d got ch %0d expected a pending record", f, frames[f].data[35:32]);
            end else begin
                pass++;
                eh = {expq[k].first, expq[k].sat, 2'b00, 4'(expq[k].ch)};
                chk++; if (frames[f].data[39:32] !== eh) $display("FAIL rand_hdr%0d: got %0h expected %0h", f, frames[f].data[39:32], eh); else pass++;
                if (!expq[k].first) begin
                    chk++; if (frames[f].data[31:0] !== expq[k].cnt) $display("FAIL rand_cnt%0d: got %0d expected %0d", f, frames[f].data[31:0], expq[k].cnt); else pass++;
                end
                expq.delete(k);
            end
        end
        esel = 2'b11;
    endtask

    task automatic test_saturation;
        frames8.delete();
        pps8[1] = 1'b1; tick(20);
        pps8[1] = 1'b0; tick(280);
        pps8[1] = 1'b1; tick(20);
        pps8[1] = 1'b0; tick(40);
        chk++; if (frames8.size() != 2) $display("FAIL sat_frames: got %0d expected 2", frames8.size()); else pass++;
        if (frames8.size() >= 2) begin
            chk++; if (frames8[0].data[15:0] !== 16'hC1FF) $display("FAIL sat_first: got %04h expected c1ff", frames8[0].data[15:0]); else pass++;
            chk++; if (frames8[1].data[15:0] !== 16'h41FF) $display("FAIL sat_second: got %04h expected 41ff", frames8[1].data[15:0]); else pass++;
            chk++; if (frames8[1].len != 2) $display("FAIL sat_len: got %0d expected 2", frames8[1].len); else pass++;
        end
        ordy8 = 1'b0; tick(100);
        pps8[1] = 1'b1;
        for (int i = 0; i < 50 && ov8 !== 1'b1; i++) tick(1);
        chk++; if (ov8 !== 1'b1) $display("FAIL mid_start: got valid %0h expected 1", ov8); else pass++;
        ordy8 = 1'b1; tick(1);
        ordy8 = 1'b0; pps8[1] = 1'b0;
        chk++; if (ol8 !== 1'b1 || od8 !== 8'd160) $display("FAIL mid_byte: got last %0h data %0d expected 1 160", ol8, od8); else pass++;
        reset = 1'b1; tick(1);
        chk++; if (ov8 !== 1'b0 || ol8 !== 1'b0) $display("FAIL mid_reset: got valid %0h last %0h expected 0 0", ov8, ol8); else pass++;
        chk++; if (od8 !== 8'h00) $display("FAIL mid_reset_data: got %0h expected 00", od8); else pass++;
        reset = 1'b0; ordy8 = 1'b1; tick(50);
        chk++; if (frames8.size() != 2) $display("FAIL mid_resume: got %0d frames expected 2", frames8.size()); else pass++;
        chk++; if (ov8 !== 1'b0) $display("FAIL mid_idle: got valid %0h expected 0", ov8); else pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tick(3);
        test_reset();
        test_latency();
        test_period();
        test_glitch();
        test_simultaneous();
        test_backpressure();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
